// File: rtl/mem_access_stage.sv
// Memory-access stage: one instruction in flight, IDLE -> (MEM) -> WB; optional ack watchdog under MEM_TIMEOUT_EN.
// Latency: 1 cycle for non-memory/misaligned ops, ack+1 for loads/stores; stalls upstream until wb_ready.
`timescale 1ns/1ps
`ifndef LOAD
`define LOAD 5'd12
`endif
`ifndef STORE
`define STORE 5'd13
`endif

module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_alufun,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu_res,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;

  logic        is_mem, is_store, acc_ok;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_byte_word, ld_half_word, ld_data;

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        bus_err_q, bus_err_d;
`endif

  always_comb begin
    is_mem   = (in_alufun == `LOAD) || (in_alufun == `STORE);
    is_store = (in_alufun == `STORE);

    // Unsupported widths (011/110/111) fall through to "not ok" and are reported as misaligned.
    case (in_funct3)
      3'b000, 3'b100: acc_ok = 1'b1;
      3'b001, 3'b101: acc_ok = ~in_alu_res[0];
      3'b010:         acc_ok = (in_alu_res[1:0] == 2'b00);
      default:        acc_ok = 1'b0;
    endcase

    case (in_funct3[1:0])
      2'b00:   begin st_wstrb = 4'b0001 << in_alu_res[1:0]; st_wdata = {4{in_store_data[7:0]}};  end
      2'b01:   begin st_wstrb = 4'b0011 << in_alu_res[1:0]; st_wdata = {2{in_store_data[15:0]}}; end
      default: begin st_wstrb = 4'b1111;                    st_wdata = in_store_data;            end
    endcase

    ld_byte_word = mem_rdata >> {lane_q, 3'b000};
    ld_half_word = mem_rdata >> {lane_q[1], 4'b0000};
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte_word[7]}}, ld_byte_word[7:0]};
      3'b100:  ld_data = {24'd0, ld_byte_word[7:0]};
      3'b001:  ld_data = {{16{ld_half_word[15]}}, ld_half_word[15:0]};
      3'b101:  ld_data = {16'd0, ld_half_word[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wb_valid_d  = wb_valid_q;
    wb_we_d     = wb_we_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    misalign_d  = misalign_q;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    bus_err_d   = bus_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          funct3_d = in_funct3;
          lane_d   = in_alu_res[1:0];
          wb_rd_d  = in_rd;
          if (is_mem && acc_ok) begin
            state_d     = S_MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {in_alu_res[31:2], 2'b00};
            mem_wdata_d = is_store ? st_wdata : 32'd0;
            mem_wstrb_d = is_store ? st_wstrb : 4'b0000;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_d   = 16'd0;
`endif
          end else begin
            state_d    = S_WB;
            wb_valid_d = 1'b1;
            wb_data_d  = in_alu_res;
            misalign_d = is_mem;
            wb_we_d    = !is_mem && (in_rd != 5'd0);
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d     = S_WB;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          wb_valid_d  = 1'b1;
          wb_we_d     = !mem_we_q && (wb_rd_q != 5'd0);
          wb_data_d   = mem_we_q ? 32'd0 : ld_data;
          misalign_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = S_WB;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          wb_valid_d  = 1'b1;
          wb_we_d     = 1'b0;
          wb_data_d   = 32'd0;
          bus_err_d   = 1'b1;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 16'd1;
`endif
        end
      end
      S_WB: begin
        if (wb_ready) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b0;
          wb_we_d    = 1'b0;
          misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
          bus_err_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      misalign_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q   <= 16'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_err      = bus_err_q;
`else
  assign bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; inputs driven and outputs sampled 1ns after each rising edge.
`timescale 1ns/1ps
`ifndef LOAD
`define LOAD 5'd12
`endif
`ifndef STORE
`define STORE 5'd13
`endif

module tb_mem_access_stage;
  localparam logic [4:0] OP_ADD = 5'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_alufun;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_res;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_ready, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err, bus_err;

  int n_total = 0;
  int n_pass  = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alufun(in_alufun), .in_funct3(in_funct3),
    .in_alu_res(in_alu_res), .in_store_data(in_store_data), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Presents one packet for a single accepting edge; returns in the cycle after accept.
  task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd);
    in_alufun     = op;
    in_funct3     = f3;
    in_alu_res    = alu;
    in_store_data = sd;
    in_rd         = rd;
    in_valid      = 1'b1;
    tick();
    in_valid      = 1'b0;
  endtask

  // Waits `delay` cycles in MEM, then pulses ack for one cycle; returns in the first WB cycle.
  task automatic respond(input int delay, input logic [31:0] rdata);
    for (int i = 0; i < delay; i++) tick();
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_0000;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_alufun = OP_ADD; in_funct3 = 3'd0;
    in_alu_res = 32'd0; in_store_data = 32'd0; in_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; wb_ready = 1'b1;
    tick(); tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // ADD passthrough
    issue(OP_ADD, 3'b000, 32'h0000_0010, 32'd0, 5'd5);
    check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("add_wb_data", wb_data, 32'h0000_0010);
    check("add_wb_we", {31'd0, wb_we}, 32'd1);
    check("add_wb_rd", {27'd0, wb_rd}, 32'd5);
    check("add_no_req", {31'd0, mem_req}, 32'd0);
    check("add_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("add_wb_done", {31'd0, wb_valid}, 32'd0);
    check("add_ready_back", {31'd0, in_ready}, 32'd1);

    // ADD to x0: no register write
    issue(OP_ADD, 3'b000, 32'h1234_5678, 32'd0, 5'd0);
    check("add_x0_we", {31'd0, wb_we}, 32'd0);
    tick();

    // LB at 0x1003, ack two cycles after req
    issue(`LOAD, 3'b000, 32'h0000_1003, 32'd0, 5'd7);
    check("lb_req", {31'd0, mem_req}, 32'd1);
    check("lb_addr", mem_addr, 32'h0000_1000);
    check("lb_we", {31'd0, mem_we}, 32'd0);
    check("lb_in_ready", {31'd0, in_ready}, 32'd0);
    respond(2, 32'h80FF_1234);
    check("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_wb_we", {31'd0, wb_we}, 32'd1);
    check("lb_req_drop", {31'd0, mem_req}, 32'd0);
    tick();

    // LBU same access
    issue(`LOAD, 3'b100, 32'h0000_1003, 32'd0, 5'd7);
    respond(2, 32'h80FF_1234);
    check("lbu_wb_data", wb_data, 32'h0000_0080);
    tick();

    // SH at 0x2002 with ack in the same cycle the request rises
    issue(`STORE, 3'b001, 32'h0000_2002, 32'hAAAA_BEEF, 5'd3);
    check("sh_req", {31'd0, mem_req}, 32'd1);
    check("sh_we", {31'd0, mem_we}, 32'd1);
    check("sh_addr", mem_addr, 32'h0000_2000);
    check("sh_wstrb", {28'd0, mem_wstrb}, 32'h0000_000C);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    respond(0, 32'h0);
    check("sh_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("sh_wb_we", {31'd0, wb_we}, 32'd0);
    tick();

    // LW at 0x3001: misaligned
    issue(`LOAD, 3'b010, 32'h0000_3001, 32'd0, 5'd4);
    check("lw_mis_req", {31'd0, mem_req}, 32'd0);
    check("lw_mis_valid", {31'd0, wb_valid}, 32'd1);
    check("lw_mis_err", {31'd0, misalign_err}, 32'd1);
    check("lw_mis_we", {31'd0, wb_we}, 32'd0);
    tick();

    // SB at 0x3001 completes normally
    issue(`STORE, 3'b000, 32'h0000_3001, 32'h0000_00A5, 5'd4);
    check("sb_req", {31'd0, mem_req}, 32'd1);
    check("sb_wstrb", {28'd0, mem_wstrb}, 32'h0000_0002);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    respond(1, 32'h0);
    check("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("sb_misalign", {31'd0, misalign_err}, 32'd0);
    tick();

    // Unsupported funct3 on a load
    issue(`LOAD, 3'b011, 32'h0000_3000, 32'd0, 5'd4);
    check("f3_bad_req", {31'd0, mem_req}, 32'd0);
    check("f3_bad_err", {31'd0, misalign_err}, 32'd1);
    tick();

    // LH with downstream stalled three cycles
    wb_ready = 1'b0;
    issue(`LOAD, 3'b001, 32'h0000_4002, 32'd0, 5'd9);
    respond(1, 32'h8001_7FFF);
    check("lh_wb_data", wb_data, 32'hFFFF_8001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("stall_wb_data", wb_data, 32'hFFFF_8001);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    tick();
    check("stall_release", {31'd0, wb_valid}, 32'd0);
    check("stall_ready_back", {31'd0, in_ready}, 32'd1);

    // LHU at lane 0
    issue(`LOAD, 3'b101, 32'h0000_4000, 32'd0, 5'd9);
    respond(0, 32'h8001_F00D);
    check("lhu_wb_data", wb_data, 32'h0000_F00D);
    tick();

    // Reset during MEM, then a late ack
    issue(`LOAD, 3'b010, 32'h0000_5000, 32'd0, 5'd6);
    check("rstmem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("rstmem_req_clr", {31'd0, mem_req}, 32'd0);
    check("rstmem_addr_clr", mem_addr, 32'd0);
    check("rstmem_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rstmem_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    respond(0, 32'h1111_2222);
    check("late_ack_wb", {31'd0, wb_valid}, 32'd0);
    tick();
    check("late_ack_wb2", {31'd0, wb_valid}, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    issue(`LOAD, 3'b010, 32'h0000_6000, 32'd0, 5'd8);
    for (int i = 0; i < 4; i++) begin
      check("tmo_req_high", {31'd0, mem_req}, 32'd1);
      tick();
    end
    check("tmo_req_low", {31'd0, mem_req}, 32'd0);
    check("tmo_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
    check("tmo_wb_we", {31'd0, wb_we}, 32'd0);
    tick();
`else
    issue(`LOAD, 3'b010, 32'h0000_6000, 32'd0, 5'd8);
    for (int i = 0; i < 6; i++) begin
      check("notmo_req_high", {31'd0, mem_req}, 32'd1);
      check("notmo_bus_err", {31'd0, bus_err}, 32'd0);
      tick();
    end
    respond(0, 32'h0BAD_CAFE);
    check("notmo_wb_data", wb_data, 32'h0BAD_CAFE);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
